spi_xfer_engine: RTL
====================

Name: spi_xfer_engine

Overview:
- Byte-oriented SPI mode-0 transfer engine (CPOL=0, CPHA=0), MSB first, full duplex, single chip select.
- Accepts a transfer command (byte count), pulls TX bytes from a valid/ready stream, and pushes RX bytes out as one-cycle pulses.
- Sits directly downstream of the SPI clock divider. It owns the divider's enable and consumes its edge strobes and rising-edge count to time MOSI shifting and MISO sampling.
- Used by the QSPI manager for single-lane command, address and status traffic.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- SPI_HZ, 12500000, SCK frequency. CLK_HZ/SPI_HZ must be an even integer ≥4; violation is a compile-time error.
- LEN_W, 16, width of the byte-count field.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- len  in  LEN_W  number of bytes in the transfer; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- rx_data  out  8  received byte
- rx_valid  out  1  one-cycle pulse; rx_data valid. No backpressure.
- spi_sck  out  1  SPI clock; idles low
- spi_cs_n  out  1  chip select, active low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset values (async, resetn=0): spi_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0. State returns to IDLE.
- Reset applied mid-transfer drops CS immediately. No done pulse is generated.
- HALF = (CLK_HZ/SPI_HZ)/2. All setup and hold intervals are HALF clk cycles.
- FSM states: IDLE, FETCH, SETUP, SHIFT, GAP, HOLD, DESEL.
- IDLE:
  - start=1 and len≠0: latch len into a remaining-byte counter, go to FETCH, set busy=1.
  - start=1 and len=0: done=1 on the next cycle. CS is never asserted and busy stays 0.
  - start outside IDLE is ignored.
- FETCH:
  - tx_ready=1.
  - On handshake: load the shift register, set spi_cs_n=0, drive spi_mosi=tx_data[7], go to SETUP.
  - While tx_valid=0 the engine waits indefinitely. SCK stays low and CS keeps its current state.
- SETUP: hold HALF cycles with the divider enable low, then assert the divider enable and enter SHIFT.
- SHIFT (divider enable high; SCK high on the first enabled cycle):
  - On each divider rising-edge strobe: shift spi_miso into the RX register LSB.
  - On each divider falling-edge strobe with rising count <8: shift TX left and present the next bit on spi_mosi.
  - Falling-edge strobe with rising count =8:
    - Deassert the divider enable.
    - Pulse rx_valid with the assembled byte.
    - Decrement the remaining-byte counter.
    - If the count is now 0, go to HOLD; otherwise go to GAP.
- GAP: one cycle, then FETCH. CS stays low between bytes; there is no CS toggle.
- HOLD: CS low for HALF cycles after the final SCK fall.
- DESEL: CS high for HALF cycles. Then done=1 for one cycle, busy=0, and return to IDLE. A new start is accepted on the following cycle.
- Falling-edge strobes outside SHIFT are ignored, including the one caused by the enable dropping.
- Exactly 8 SCK rising edges per byte. SCK never runs while CS is high.
- The remaining-byte counter is LEN_W wide. len=2^LEN_W−1 is legal; there is no wrap.

Decomposition:
- Shared package spi_pkg holds:
  - the FSM state enum;
  - BITS_PER_BYTE=8;
  - a localparam function computing HALF from CLK_HZ/SPI_HZ.
- One sub-module: the existing spi_clk_div, instantiated with CLKIN_HZ=CLK_HZ, CLKOUT_HZ=SPI_HZ and CYCLE_COUNT_WIDTH=4.
- Its clkout drives spi_sck. Its rising/falling strobes and cycle_count feed the FSM.

Test Plan:
- Single byte, defaults (HALF=4), len=1, tx 0xA5, slave MISO 0x3C:
  - 8 SCK periods of 8 clk each;
  - MOSI bits 1,0,1,0,0,1,0,1 stable at every rising edge;
  - rx_data=0x3C with one rx_valid pulse;
  - CS low ≥4 clk before the first SCK rise and ≥4 clk after the last fall;
  - exactly one done pulse.
- Three bytes, tx 0x01,0x80,0xFF, loopback MOSI→MISO: rx pulses 0x01, 0x80, 0xFF; CS stays low across all three bytes; 24 SCK rising edges in total.
- TX stall: tx_valid held low for 50 clk before byte 2 → SCK low and CS low throughout the stall; transfer resumes correctly; rx of byte 2 is correct.
- len=0 start → done pulse on the next cycle; CS stays 1; no SCK edges; no tx_ready.
- start pulsed while busy=1 at byte 1 bit 3 → ignored; byte count unchanged; exactly one done pulse.
- resetn low mid-SHIFT of byte 2 → spi_cs_n=1, spi_sck=0 and busy=0 the same cycle; no done pulse; after release, a fresh 1-byte transfer completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, byte width and half-period helper for the SPI engine
package spi_pkg;
  localparam int BITS_PER_BYTE = 8;
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, SHIFT, GAP, HOLD, DESEL} state_t;
  function automatic int half_cycles(input int clk_hz, input int spi_hz);
    return clk_hz / spi_hz / 2;
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: gated SCK generator with edge strobes and a rising-edge counter
//   clkin/resetn : system clock, async active-low reset
//   enable       : runs the clock; low forces clkout low and clears all counters
//   clkout       : SCK, high on the first enabled cycle
//   rising/falling: one-cycle strobes in the first cycle of each SCK level
//   cycle_count  : rising edges seen since enable went high
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLKIN_HZ = 100_000_000,
  parameter int CLKOUT_HZ = 12_500_000,
  parameter int CYCLE_COUNT_WIDTH = 4
) (
  input  logic clkin,
  input  logic resetn,
  input  logic enable,
  output logic clkout,
  output logic rising,
  output logic falling,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count
);
  localparam int HALF = half_cycles(CLKIN_HZ, CLKOUT_HZ);
  localparam int CW = $clog2(HALF);
  logic [CW-1:0] cnt;
  logic phase;
  // clkout is gated combinationally so SCK rises in the very cycle enable does
  assign clkout = enable & ~phase;
  assign rising = enable & ~phase & (cnt == '0);
  assign falling = enable & phase & (cnt == '0);
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      phase <= 1'b0;
      cycle_count <= '0;
    end else if (!enable) begin
      cnt <= '0;
      phase <= 1'b0;
      cycle_count <= '0;
    end else begin
      cnt <= (cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
      phase <= (cnt == CW'(HALF - 1)) ? ~phase : phase;
      cycle_count <= rising ? cycle_count + 1'b1 : cycle_count;
    end
  end
endmodule

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI mode-0 MSB-first full-duplex byte transfer engine
//   clk/resetn           : system clock, async active-low reset
//   start/len/busy/done  : command strobe with byte count, activity flag, end pulse
//   tx_data/valid/ready  : TX byte stream
//   rx_data/rx_valid     : RX byte with one-cycle valid pulse
//   spi_sck/cs_n/mosi/miso: SPI pins
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int SPI_HZ = 12_500_000,
  parameter int LEN_W = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic [LEN_W-1:0] len,
  output logic busy,
  output logic done,
  input  logic [7:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [7:0] rx_data,
  output logic rx_valid,
  output logic spi_sck,
  output logic spi_cs_n,
  output logic spi_mosi,
  input  logic spi_miso
);
  localparam int HALF = half_cycles(CLK_HZ, SPI_HZ);
  localparam int TW = $clog2(HALF);
  if (CLK_HZ % SPI_HZ != 0 || (CLK_HZ / SPI_HZ) % 2 != 0 || CLK_HZ / SPI_HZ < 4) begin : g_bad_ratio
    $error("CLK_HZ/SPI_HZ must be an even integer >= 4");
  end
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic [LEN_W-1:0] rem;
  logic [7:0] tx_sh, rx_sh;
  logic [3:0] cyc;
  logic en, rise, fall, hs, in_shift, tmr_end, last_fall;
  spi_clk_div #(.CLKIN_HZ(CLK_HZ), .CLKOUT_HZ(SPI_HZ), .CYCLE_COUNT_WIDTH(4)) u_div (
    .clkin(clk), .resetn(resetn), .enable(en), .clkout(spi_sck),
    .rising(rise), .falling(fall), .cycle_count(cyc)
  );
  assign tx_ready = state == FETCH;
  assign hs = tx_valid & tx_ready;
  assign in_shift = state == SHIFT;
  assign tmr_end = tmr == TW'(HALF - 1);
  assign last_fall = in_shift & fall & (cyc == 4'(BITS_PER_BYTE));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (start && len != '0) ? FETCH : IDLE;
      FETCH:   nxt = hs ? SETUP : FETCH;
      SETUP:   nxt = tmr_end ? SHIFT : SETUP;
      SHIFT:   nxt = last_fall ? ((rem == LEN_W'(1)) ? HOLD : GAP) : SHIFT;
      GAP:     nxt = FETCH;
      HOLD:    nxt = tmr_end ? DESEL : HOLD;
      DESEL:   nxt = tmr_end ? IDLE : DESEL;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr <= '0;
      rem <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      rx_valid <= 1'b0;
      // every timed state starts counting from zero on entry
      tmr <= (nxt != state) ? '0 : tmr + 1'b1;
      if (state == IDLE && start) begin
        rem <= len;
        busy <= len != '0;
        done <= len == '0;
      end
      if (hs) begin
        tx_sh <= tx_data;
        spi_mosi <= tx_data[7];
        spi_cs_n <= 1'b0;
      end
      if (state == SETUP && tmr_end) en <= 1'b1;
      if (in_shift && rise) rx_sh <= {rx_sh[6:0], spi_miso};
      if (in_shift && fall && !last_fall) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
        spi_mosi <= tx_sh[6];
      end
      if (last_fall) begin
        en <= 1'b0;
        rx_valid <= 1'b1;
        rx_data <= rx_sh;
        rem <= rem - 1'b1;
      end
      if (state == HOLD && tmr_end) spi_cs_n <= 1'b1;
      if (state == DESEL && tmr_end) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule
